// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between requesters and the round-robin arbiter.
//   req          requester -> arbiter, per-requester request level
//   grant_ack    requester -> arbiter, single-cycle "current grant finished" pulse
//   grant        arbiter -> requester, one-hot grant vector
//   grant_index  arbiter -> requester, binary index of the granted requester
//   grant_valid  arbiter -> requester, high while a grant is active
interface rr_arbiter_if #(
    parameter int N  = 4,
    parameter int LN = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]  req;
    logic          grant_ack;
    logic [N-1:0]  grant;
    logic [LN-1:0] grant_index;
    logic          grant_valid;

    modport master (output req, grant_ack, input grant, grant_index, grant_valid);
    modport slave  (input req, grant_ack, output grant, grant_index, grant_valid);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter for N requesters with optional grant locking.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter_if slave: req/grant_ack in, grant/grant_index/grant_valid out
module rr_arbiter #(
    parameter int N    = 4,
    parameter int LOCK = 1,
    localparam int LN  = (N > 1) ? $clog2(N) : 1
) (
    input logic   clk,
    input logic   rst_n,
    rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANTED} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d, mask_q, mask_d, rest, rel_mask;
    logic [LN-1:0] idx_q, idx_d;
    logic [N:0]    rel_span;
    logic [LN:0]   pick_idle, pick_rel;
    logic          release_now;

    // Returns {found, winner}: lowest masked request if any, else lowest request.
    function automatic logic [LN:0] pick(input logic [N-1:0] r, input logic [N-1:0] m);
        logic [N-1:0]  masked;
        logic [LN-1:0] lo_m, lo_r;
        masked = r & m;
        lo_m = '0;
        lo_r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) lo_m = LN'(i);
            if (r[i]) lo_r = LN'(i);
        end
        return {|r, (|masked) ? lo_m : lo_r};
    endfunction

    // Mask after releasing idx_q: only bits strictly above it; N+1 bits so index N-1 wraps to 0.
    assign rel_span    = ((N + 1)'(2) << idx_q) - (N + 1)'(1);
    assign rel_mask    = ~rel_span[N-1:0];
    assign rest        = bus.req & ~grant_q;
    assign pick_idle   = pick(bus.req, mask_q);
    assign pick_rel    = pick(rest, rel_mask);
    assign release_now = (state_q == GRANTED) && ((LOCK == 0) || bus.grant_ack || !bus.req[idx_q]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        if (state_q == IDLE) begin
            if (pick_idle[LN]) begin
                state_d = GRANTED;
                idx_d   = pick_idle[LN-1:0];
                grant_d = N'(1) << pick_idle[LN-1:0];
            end
        end else if (release_now) begin
            mask_d  = rel_mask;
            state_d = pick_rel[LN] ? GRANTED : IDLE;
            idx_d   = pick_rel[LN] ? pick_rel[LN-1:0] : '0;
            grant_d = pick_rel[LN] ? N'(1) << pick_rel[LN-1:0] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_index = idx_q;
    assign bus.grant_valid = (state_q == GRANTED);
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter, LOCK=1 and LOCK=0 instances with N=4.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int failed = 0;
    logic [6:0] exp_q[$];
    logic [6:0] got, e;

    always #5 clk = ~clk;

    rr_arbiter_if #(.N(4)) bus1();
    rr_arbiter_if #(.N(4)) bus0();

    rr_arbiter #(.N(4), .LOCK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    rr_arbiter #(.N(4), .LOCK(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic do_reset;
        bus1.req = '0;
        bus1.grant_ack = 1'b0;
        bus0.req = '0;
        bus0.grant_ack = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        bus1.req = 4'b1111;
        bus1.grant_ack = 1'b0;
        bus0.req = 4'b1111;
        bus0.grant_ack = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.push_back(7'b0_0000_00);
        #1;
        e = exp_q.pop_front();
        got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
        tests++;
        if (got !== e) begin failed++; $display("FAIL reset_async: got %b expected %b", got, e); end
        exp_q.push_back(7'b0_0000_00);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        got = {bus0.grant_valid, bus0.grant, bus0.grant_index};
        tests++;
        if (got !== e) begin failed++; $display("FAIL reset_held: got %b expected %b", got, e); end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap;
        logic [3:0] rq [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000};
        bit         ak [4] = '{0, 1, 1, 0};
        logic [6:0] ex [4] = '{7'b1_0010_01, 7'b1_1000_11, 7'b1_0010_01, 7'b0_0000_00};
        do_reset();
        foreach (rq[k]) begin
            bus1.req = rq[k];
            bus1.grant_ack = ak[k];
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL wrap step %0d: got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_fairness;
        logic [6:0] ex [6] = '{7'b1_0001_00, 7'b1_0010_01, 7'b1_0100_10,
                               7'b1_1000_11, 7'b1_0001_00, 7'b1_0010_01};
        do_reset();
        bus1.req = 4'b1111;
        bus1.grant_ack = 1'b1;
        foreach (ex[k]) begin
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL fairness step %0d: got %b expected %b", k, got, e); end
        end
        bus1.grant_ack = 1'b0;
    endtask

    task automatic test_withdraw;
        logic [3:0] rq [9] = '{4'b0100, 4'b0100, 4'b1100, 4'b1000, 4'b0000,
                               4'b0100, 4'b0000, 4'b1111, 4'b1111};
        bit         ak [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [6:0] ex [9] = '{7'b1_0100_10, 7'b1_0100_10, 7'b1_0100_10, 7'b1_1000_11, 7'b0_0000_00,
                               7'b1_0100_10, 7'b0_0000_00, 7'b1_1000_11, 7'b1_0001_00};
        do_reset();
        foreach (rq[k]) begin
            bus1.req = rq[k];
            bus1.grant_ack = ak[k];
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL withdraw step %0d: got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_regrant;
        logic [3:0] rq [5] = '{4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
        bit         ak [5] = '{1, 1, 1, 1, 0};
        logic [6:0] ex [5] = '{7'b0_0000_00, 7'b1_0010_01, 7'b1_0100_10, 7'b0_0000_00, 7'b1_0100_10};
        do_reset();
        foreach (rq[k]) begin
            bus1.req = rq[k];
            bus1.grant_ack = ak[k];
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL regrant step %0d: got %b expected %b", k, got, e); end
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] rq [2] = '{4'b0010, 4'b1000};
        logic [6:0] ex [2] = '{7'b1_0010_01, 7'b1_1000_11};
        do_reset();
        foreach (rq[k]) begin
            bus1.req = rq[k];
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL midreset_setup step %0d: got %b expected %b", k, got, e); end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(7'b0_0000_00);
        #1;
        e = exp_q.pop_front();
        got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
        tests++;
        if (got !== e) begin failed++; $display("FAIL midreset_clear: got %b expected %b", got, e); end
        bus1.req = 4'b1111;
        #1 rst_n = 1'b1;
        exp_q.push_back(7'b1_0001_00);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        got = {bus1.grant_valid, bus1.grant, bus1.grant_index};
        tests++;
        if (got !== e) begin failed++; $display("FAIL midreset_first_grant: got %b expected %b", got, e); end
    endtask

    task automatic test_lock0;
        logic [3:0] rq [7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0101};
        bit         ak [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [6:0] ex [7] = '{7'b1_0001_00, 7'b1_0010_01, 7'b1_0001_00, 7'b1_0010_01,
                               7'b0_0000_00, 7'b0_0000_00, 7'b1_0100_10};
        do_reset();
        foreach (rq[k]) begin
            bus0.req = rq[k];
            bus0.grant_ack = ak[k];
            exp_q.push_back(ex[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus0.grant_valid, bus0.grant, bus0.grant_index};
            tests++;
            if (got !== e) begin failed++; $display("FAIL lock0 step %0d: got %b expected %b", k, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_fairness();
        test_withdraw();
        test_regrant();
        test_async_reset();
        test_lock0();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter LN, default (N>1 ? clog2(N) : 1), index width; derived, not overridden.
REQ-003 Parameter LOCK, default 1; 1 = grant held until ack or withdrawal, 0 = grant held exactly one cycle.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N  per-requester request level, bit i = requester i.
REQ-007 grant_ack  input  1  single-cycle pulse from consumer; current grant finished.
REQ-008 grant  output  N  registered one-hot grant vector.
REQ-009 grant_index  output  LN  registered binary index of granted requester.
REQ-010 grant_valid  output  1  registered; high while a grant is active.

Function
REQ-011 The block shall be a two-state machine: IDLE (grant_valid=0) and GRANTED (grant_valid=1); all outputs come directly from flops.
REQ-012 The block shall keep an N-bit priority mask register; reset value all ones.
REQ-013 Arbitration, combinational: masked = req & mask; winner = lowest set bit of masked if masked nonzero, else lowest set bit of req; found = |req.
REQ-014 IDLE: if found at a rising edge, the block shall load grant=onehot(winner), grant_index=winner, grant_valid=1, enter GRANTED; otherwise stay IDLE with grant=0.
REQ-015 Latency: req asserted before edge k shall give grant_valid=1 after edge k (one cycle); no combinational path from req to outputs.
REQ-016 GRANTED, LOCK=1: release occurs at an edge where grant_ack=1 or req[grant_index]=0 (withdrawal); otherwise grant, grant_index and mask hold unchanged.
REQ-017 GRANTED, LOCK=0: release occurs at every edge.
REQ-018 On release, mask shall load bits strictly above grant_index set, all others clear (mask = ~((2 << grant_index) - 1), width N).
REQ-019 On release, arbitration shall use the updated mask with req excluding the released bit; if any other request exists, the new grant loads at the same edge (back-to-back, no bubble) and state stays GRANTED.
REQ-020 On release with no other request, outputs shall clear to grant=0, grant_index=0, grant_valid=0, state IDLE; the released requester is re-granted only after one IDLE cycle.
REQ-021 Wrap-around: release of index N-1 shall yield mask=0, so the next winner is the lowest set req bit.
REQ-022 grant_ack while IDLE shall be ignored, with no state or mask change.
REQ-023 grant shall always be one-hot or zero, and grant_index shall equal the position of the set bit (0 when grant=0).
REQ-024 Any X on req bits not selected shall not propagate to outputs; unknown req with found undeterminable is out of scope.
REQ-025 Fairness: with all N requests held high and ack every cycle, grants shall cycle 0,1,...,N-1,0 without skip or repeat.

Reset
REQ-026 rst_n low shall immediately and asynchronously force grant=0, grant_index=0, grant_valid=0, state IDLE, mask=all ones.
REQ-027 Reset asserted mid-grant shall discard the grant without any release or mask update; after deassertion, priority restarts from bit 0.
REQ-028 Deassertion shall take effect on the first rising clk edge after rst_n goes high; that edge may already grant.

Verification (N=4, LOCK=1 unless stated)
REQ-029 req=4'b1010 from reset -> after 1 edge grant=0010, index=1; ack -> grant=1000, index=3; ack -> grant=0010, index=1 (wrap).
REQ-030 req=4'b1111 held, ack every cycle -> index sequence 0,1,2,3,0,1 with grant_valid continuously 1.
REQ-031 grant on index 2, req[2] dropped without ack -> next edge grant moves to next requester above 2 or clears to 0 if none; mask=4'b1000.
REQ-032 Single req=4'b0100, ack -> one IDLE cycle (grant_valid=0), then re-grant index 2.
REQ-033 rst_n pulsed low while grant=1000 -> outputs 0 asynchronously; after release with req=1111, first grant index=0.
REQ-034 LOCK=0, req=4'b0011 held, no ack -> grants alternate 0001, 0010 every cycle; grant_ack while grant_valid=0 has no effect.
